lsu: RTL

Load/store unit sitting between the core datapath and the data-memory bus. It executes the memory half of a decoded instruction, driven by the controller's `memwrite`, `memtoreg` and `memsize` outputs plus the ALU-computed address. It generates byte enables and lane-shifted write data, sign- or zero-extends load data, and splits word-boundary-crossing accesses into two bus beats. It stalls the core through a ready/valid handshake.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/lsu_align.sv | 42 ++++
 rtl/lsu.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: memsize (funct3) encodings and the load/store unit state type.
package riscv_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} lsu_state_t;

  // Byte-lane mask of an access of the given size, anchored at lane 0.
  function automatic logic [3:0] size_mask(input logic [2:0] sz);
    case (sz[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit: store lanes, split/illegal
// detection for an incoming request, and extract/extend of a two-word load window.
module lsu_align import riscv_pkg::*; (
  input  logic        i_memwrite,
  input  logic        i_memtoreg,
  input  logic [2:0]  i_memsize,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic [63:0] i_ld_word,
  output logic [7:0]  o_be64,
  output logic [63:0] o_wd64,
  output logic        o_split,
  output logic        o_illegal,
  output logic [31:0] o_ldata
);

  logic [31:0] w_shifted;

  always_comb begin
    o_be64    = {4'b0000, size_mask(i_memsize)} << i_off;
    o_wd64    = {32'b0, i_wdata} << {i_off, 3'b000};
    o_split   = |o_be64[7:4];
    o_illegal = (i_memwrite == i_memtoreg) ||
                (i_memsize inside {3'b011, 3'b110, 3'b111}) ||
                (i_memwrite && i_memsize[2]);
  end

  assign w_shifted = 32'(i_ld_word >> {i_ld_off, 3'b000});

  always_comb begin
    case (i_ld_size)
      MEM_B:   o_ldata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      MEM_BU:  o_ldata = {24'b0, w_shifted[7:0]};
      MEM_H:   o_ldata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      MEM_HU:  o_ldata = {16'b0, w_shifted[15:0]};
      default: o_ldata = w_shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: turns one accepted memory request into one or two word-aligned
// bus beats and returns a single-cycle response with extended load data.
module lsu import riscv_pkg::*; #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              memwrite,
  input  logic              memtoreg,
  input  logic [2:0]        memsize,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  lsu_state_t        r_state, w_next;
  logic              r_we, r_ld, r_split, r_err;
  logic [2:0]        r_size;
  logic [1:0]        r_off;
  logic [ADDR_W-1:0] r_base;
  logic [7:0]        r_be64;
  logic [63:0]       r_wd64;
  logic [31:0]       r_lo, r_hi, r_rdata;

  logic [7:0]  w_be64;
  logic [63:0] w_wd64;
  logic        w_split, w_illegal, w_accept, w_fin;
  logic [31:0] w_lo, w_hi, w_ldata;

  // Feed the beat's bus data straight into the extractor so the result is ready on the final ack.
  assign w_lo     = (r_state == BEAT0) ? bus_rdata : r_lo;
  assign w_hi     = (r_state == BEAT1) ? bus_rdata : r_hi;
  assign w_accept = (r_state == IDLE) && req_valid;
  assign w_fin    = bus_ack && (((r_state == BEAT0) && !r_split) || (r_state == BEAT1));

  lsu_align u_align (
    .i_memwrite (memwrite),
    .i_memtoreg (memtoreg),
    .i_memsize  (memsize),
    .i_off      (addr[1:0]),
    .i_wdata    (wdata),
    .i_ld_size  (r_size),
    .i_ld_off   (r_off),
    .i_ld_word  ({w_hi, w_lo}),
    .o_be64     (w_be64),
    .o_wd64     (w_wd64),
    .o_split    (w_split),
    .o_illegal  (w_illegal),
    .o_ldata    (w_ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = w_illegal ? DONE : BEAT0;
      BEAT0:   if (bus_ack) w_next = r_split ? BEAT1 : DONE;
      BEAT1:   if (bus_ack) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_ld    <= 1'b0;
      r_split <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= '0;
      r_off   <= '0;
      r_base  <= '0;
      r_be64  <= '0;
      r_wd64  <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= memwrite;
        r_ld    <= memtoreg;
        r_size  <= memsize;
        r_off   <= addr[1:0];
        r_base  <= {addr[ADDR_W-1:2], 2'b00};
        r_be64  <= w_be64;
        r_wd64  <= w_wd64;
        r_split <= w_split;
        r_lo    <= '0;
        r_hi    <= '0;
        if (w_illegal) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end
      end
      if ((r_state == BEAT0) && bus_ack) r_lo <= bus_rdata;
      if ((r_state == BEAT1) && bus_ack) r_hi <= bus_rdata;
      if (w_fin) begin
        r_err   <= 1'b0;
        r_rdata <= r_ld ? w_ldata : 32'b0;
      end
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == DONE);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_be    = 4'b0000;
    bus_wdata = 32'b0;
    if (r_state == BEAT0) begin
      bus_req   = 1'b1;
      bus_we    = r_we;
      bus_addr  = r_base;
      bus_be    = r_be64[3:0];
      bus_wdata = r_wd64[31:0];
    end else if (r_state == BEAT1) begin
      bus_req   = 1'b1;
      bus_we    = r_we;
      bus_addr  = r_base + ADDR_W'(4);
      bus_be    = r_be64[7:4];
      bus_wdata = r_wd64[63:32];
    end
  end

endmodule
